sha256_stream_manager: RTL
==========================

SHA256_STREAM_MANAGER -- requirements
Module: sha256_stream_manager

Interface
REQ-001 Parameter IF_DATA_W, default 128, input beat width; SHALL divide 512 evenly and be at least 32.
REQ-002 Parameter BLK_CNT_W, default 16, width of the per-message block counter.
REQ-003 Derived constant BEATS = 512/IF_DATA_W SHALL be the number of beats per block.
REQ-004 clk  in  1  single clock; all state SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 src_manager_data_val / src_manager_data / src_manager_data_last  in  1/IF_DATA_W/1  input beat, its data, and the end-of-message marker.
REQ-007 src_manager_data_mode  in  1  1=SHA-256, 0=SHA-224; sampled on the first beat of each message only.
REQ-008 manager_src_rdy  out  1  beat accepted when val&rdy.
REQ-009 manager_core_init / manager_core_next / manager_core_mode  out  1/1/1  core strobes and the latched message mode.
REQ-010 manager_core_block  out  512  assembled block, first beat in bits [511 -: IF_DATA_W].
REQ-011 core_manager_ready / core_manager_digest_valid / core_manager_digest  in  1/1/256  core status and result.
REQ-012 manager_dst_digest_val / manager_dst_digest / manager_dst_digest_err  out  1/256/1  result handshake, digest, and early-last flag.
REQ-013 dst_manager_digest_rdy  in  1  result consumed when val&rdy.

Function
REQ-014 FSM states SHALL be IDLE, COLLECT, ISSUE, WAIT_DIGEST and OUTPUT.
REQ-015 IDLE: rdy=1; an accepted beat SHALL write beat slot 0, latch mode, set first=1, clear err, beat_cnt=1, and go to COLLECT (or ISSUE if BEATS==1 or last).
REQ-016 COLLECT: rdy=1; accepted beats SHALL fill slot beat_cnt; at slot BEATS-1 or on last, go to ISSUE.
REQ-017 Last on a beat other than BEATS-1 SHALL zero-fill the remaining slots and set err.
REQ-018 ISSUE: rdy=0; when core_manager_ready=1, SHALL pulse init (first=1) or next (first=0) for exactly one cycle, clear first, and increment blk_cnt (saturating).
REQ-019 After ISSUE, SHALL go to WAIT_DIGEST if the message is ended, else to COLLECT with beat_cnt=0.
REQ-020 The core captures the block on the strobe cycle; beats of the next block SHALL be accepted from the following cycle while the core is busy (overlap).
REQ-021 The ISSUE strobe of a later block SHALL wait for core_manager_ready=1.
REQ-022 WAIT_DIGEST: on core_manager_digest_valid, SHALL capture the digest and assert val in the same cycle (digest bypassed combinationally); if rdy, go to IDLE, else go to OUTPUT.
REQ-023 OUTPUT: val=1 with the digest and err held stable until rdy, then go to IDLE.
REQ-024 In SHA-224 mode, the digest SHALL be output with bits [31:0] forced to zero.
REQ-025 No new message beat SHALL be accepted before the previous digest is consumed.
REQ-026 Undefined state encodings SHALL drive X on all outputs and next-state.

Reset
REQ-027 Reset SHALL force IDLE immediately, mid-operation included.
REQ-028 Reset SHALL clear beat_cnt, blk_cnt, first, err, the digest register and the block register.
REQ-029 Under reset, all strobe, valid and rdy outputs SHALL read 0.

Configuration
REQ-030 With SHA256_MGR_BLKCNT_EN defined, output port manager_dst_block_cnt [BLK_CNT_W] SHALL present the message block count with the digest, held like the digest.
REQ-031 Without SHA256_MGR_BLKCNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 The state enum, SHA256_BLOCK_W=512 and SHA256_DIGEST_W=256 SHALL reside in the shared sha256 package/defs.
REQ-033 Block assembly (slot write, zero-fill, beat counter) SHALL be one sub-module, sha256_block_assembler.

Verification
REQ-034 IF_DATA_W=128, "abc" padded as 4 beats, mode=1 -> one init pulse, digest ba7816bf...f20015ad, err=0.
REQ-035 Same input, mode=0 -> core_mode=0, low 32 digest bits zero.
REQ-036 3-block message, core_manager_ready held low 20 cycles after each strobe -> init, next, next; next-block beats accepted during the busy window; blk_cnt=3.
REQ-037 Last on beat 1 of 4 -> slots 2-3 zero, err=1 with the digest.
REQ-038 dst_manager_digest_rdy low 10 cycles -> val and digest stable, rdy=0 to source, IDLE after the handshake.
REQ-039 rst pulsed mid-COLLECT (asynchronously to clk) -> outputs 0 at once; next message starts with an init pulse.

Source files
------------

// File: rtl/sha256_stream_manager_pkg.sv
// sha256_stream_manager_pkg: shared SHA-256 widths, manager state enum and SHA-224 digest masking
package sha256_stream_manager_pkg;
  localparam int SHA256_BLOCK_W = 512;
  localparam int SHA256_DIGEST_W = 256;
  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT_DIGEST, OUTPUT} mgr_state_t;
  function automatic logic [SHA256_DIGEST_W-1:0] mask_digest(input logic [SHA256_DIGEST_W-1:0] d, input logic mode);
    return mode ? d : {d[SHA256_DIGEST_W-1:32], 32'h0};
  endfunction
endpackage

// File: rtl/sha256_block_assembler.sv
// sha256_block_assembler: writes input beats into 512-bit block slots, zero-filling the tail after an early last
module sha256_block_assembler
  import sha256_stream_manager_pkg::*;
#(
  parameter int W = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr,
  input  logic [W-1:0]              data,
  input  logic                      last,
  output logic [SHA256_BLOCK_W-1:0] block,
  output logic                      done,
  output logic                      early
);
  localparam int BEATS = SHA256_BLOCK_W / W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [W-1:0] slots [BEATS];
  logic [CW-1:0] beat_cnt;
  logic at_end;
  assign at_end = int'(beat_cnt) == BEATS - 1;
  assign done = wr && (last || at_end);
  assign early = wr && last && !at_end;
  // Slot write; the counter wraps to 0 at every block end so a new block or message always starts at slot 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      beat_cnt <= '0;
      for (int i = 0; i < BEATS; i++) slots[i] <= '0;
    end else if (wr) begin
      beat_cnt <= (last || at_end) ? '0 : beat_cnt + 1'b1;
      for (int i = 0; i < BEATS; i++)
        if (i == int'(beat_cnt)) slots[i] <= data;
        else if (last && i > int'(beat_cnt)) slots[i] <= '0;
    end
  for (genvar g = 0; g < BEATS; g++) begin : g_pack
    assign block[SHA256_BLOCK_W-1-g*W -: W] = slots[g];
  end
endmodule

// File: rtl/sha256_stream_manager.sv
// sha256_stream_manager: streams beats into blocks, sequences the core, returns the digest (SHA256_MGR_BLKCNT_EN adds manager_dst_block_cnt)
module sha256_stream_manager
  import sha256_stream_manager_pkg::*;
#(
  parameter int IF_DATA_W = 128,
  parameter int BLK_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       src_manager_data_val,
  input  logic [IF_DATA_W-1:0]       src_manager_data,
  input  logic                       src_manager_data_last,
  input  logic                       src_manager_data_mode,
  output logic                       manager_src_rdy,
  output logic                       manager_core_init,
  output logic                       manager_core_next,
  output logic                       manager_core_mode,
  output logic [SHA256_BLOCK_W-1:0]  manager_core_block,
  input  logic                       core_manager_ready,
  input  logic                       core_manager_digest_valid,
  input  logic [SHA256_DIGEST_W-1:0] core_manager_digest,
  output logic                       manager_dst_digest_val,
  output logic [SHA256_DIGEST_W-1:0] manager_dst_digest,
  output logic                       manager_dst_digest_err,
  input  logic                       dst_manager_digest_rdy
`ifdef SHA256_MGR_BLKCNT_EN
  , output logic [BLK_CNT_W-1:0]     manager_dst_block_cnt
`endif
);
  mgr_state_t state;
  logic first, err, ended, mode, acc, blk_done, early;
  logic rdy_c, init_c, next_c, val_c, err_c;
  logic [SHA256_DIGEST_W-1:0] digest_q, digest_in, dig_c;
  assign acc = src_manager_data_val && manager_src_rdy;
  assign digest_in = mask_digest(core_manager_digest, mode);
  sha256_block_assembler #(.W(IF_DATA_W)) u_asm (
    .clk(clk), .rst(rst), .wr(acc), .data(src_manager_data), .last(src_manager_data_last),
    .block(manager_core_block), .done(blk_done), .early(early)
  );
  // State-decoded outputs; the digest is bypassed from the core in the cycle it becomes valid
  always_comb begin
    rdy_c = 1'b0;
    init_c = 1'b0;
    next_c = 1'b0;
    val_c = 1'b0;
    err_c = err;
    dig_c = digest_q;
    case (state)
      IDLE, COLLECT: rdy_c = 1'b1;
      ISSUE: begin
        init_c = core_manager_ready && first;
        next_c = core_manager_ready && !first;
      end
      WAIT_DIGEST: begin
        val_c = core_manager_digest_valid;
        dig_c = digest_in;
      end
      OUTPUT: val_c = 1'b1;
      default: begin
        rdy_c = 1'bx;
        init_c = 1'bx;
        next_c = 1'bx;
        val_c = 1'bx;
        err_c = 1'bx;
        dig_c = 'x;
      end
    endcase
  end
  assign manager_src_rdy = rdy_c && !rst;
  assign manager_core_init = init_c;
  assign manager_core_next = next_c;
  assign manager_core_mode = mode;
  assign manager_dst_digest_val = val_c;
  assign manager_dst_digest = dig_c;
  assign manager_dst_digest_err = err_c;
  // Message sequencing: collect a block, strobe the core, overlap the next block, then hand off the digest
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      first <= 1'b0;
      err <= 1'b0;
      ended <= 1'b0;
      mode <= 1'b0;
      digest_q <= '0;
    end else
      case (state)
        IDLE: if (acc) begin
          mode <= src_manager_data_mode;
          first <= 1'b1;
          err <= early;
          ended <= src_manager_data_last;
          state <= blk_done ? ISSUE : COLLECT;
        end
        COLLECT: if (acc) begin
          err <= err | early;
          ended <= src_manager_data_last;
          if (blk_done) state <= ISSUE;
        end
        ISSUE: if (core_manager_ready) begin
          first <= 1'b0;
          state <= ended ? WAIT_DIGEST : COLLECT;
        end
        WAIT_DIGEST: if (core_manager_digest_valid) begin
          digest_q <= digest_in;
          state <= dst_manager_digest_rdy ? IDLE : OUTPUT;
        end
        OUTPUT: if (dst_manager_digest_rdy) state <= IDLE;
        default: state <= mgr_state_t'('x);
      endcase
`ifdef SHA256_MGR_BLKCNT_EN
  logic [BLK_CNT_W-1:0] blk_cnt;
  // Saturating per-message block count, restarted by the first beat of a message and held with the digest
  always_ff @(posedge clk or posedge rst)
    if (rst) blk_cnt <= '0;
    else if (state == IDLE && acc) blk_cnt <= '0;
    else if (init_c || next_c) blk_cnt <= &blk_cnt ? blk_cnt : blk_cnt + 1'b1;
  assign manager_dst_block_cnt = blk_cnt;
`endif
endmodule
